commit_ctrl: RTL
================

// Module: commit_ctrl
// PURPOSE
// Commit-width controller sitting directly upstream of the head-pointer block.
// Inspects the COMMIT_WIDTH oldest ROB entries each cycle and decides how many retire.
// Produces ramt (ROB entries retired) and amt (IQ entries released) combinationally, so head pointers advance on the same edge.
// Sequences exception flushes and keeps commit/stall statistics.
// PARAMETERS
// COMMIT_WIDTH  3   ROB head slots examined per cycle (max 7; ramt/amt are 3 bits)
// FLUSH_CYCLES  4   cycles flush stays asserted after an exception commits
// CAUSE_W       8   exception cause width
// PORTS
// clk           in   1                      clock
// rst           in   1                      synchronous active-high reset
// head_v        in   COMMIT_WIDTH           slot k holds a valid ROB entry (slot 0 = oldest)
// head_done     in   COMMIT_WIDTH           slot k result written back
// head_exc      in   COMMIT_WIDTH           slot k faulted
// head_store    in   COMMIT_WIDTH           slot k is a store
// head_iqrel    in   COMMIT_WIDTH           slot k still owns an IQ entry
// head_cause    in   COMMIT_WIDTH*CAUSE_W   per-slot cause; slot k at [k*CAUSE_W +: CAUSE_W]
// sb_full       in   1                      store buffer cannot accept
// ramt          out  3                      ROB entries retired this cycle
// amt           out  3                      IQ entries released this cycle
// flush         out  1                      pipeline flush request
// exc_valid     out  1                      one-cycle pulse: exception committed
// exc_cause     out  CAUSE_W                cause of last committed exception
// commit_cnt    out  32                     total retired entries
// stall_cnt     out  32                     RUN cycles with a valid head and ramt==0
// BEHAVIOUR
// - Reset: state=RUN; flush=0; exc_valid=0; exc_cause=0; commit_cnt=0; stall_cnt=0; flush counter=0.
// - Reset has priority over all events, including mid-FLUSH; while rst=1, ramt=amt=0.
// - State machine: RUN, FLUSH.
//   - RUN -> FLUSH when an exception commits.
//   - FLUSH -> RUN after FLUSH_CYCLES cycles.
// - RUN, per slot k in order 0..COMMIT_WIDTH-1, a slot is retirable if all of:
//   - v & done & !exc;
//   - if store: !sb_full and no earlier store retires this cycle (max 1 store/cycle).
// - ramt = length of the leading run of retirable slots; the first non-retirable slot ends the scan.
// - Exception at slot 0 (v & done & exc), RUN:
//   - ramt=1, amt=head_iqrel[0]; exc_valid pulses the next cycle.
//   - exc_cause <= head_cause slot 0; flush=1 from the next cycle for FLUSH_CYCLES cycles.
// - Exception at slot k>0: only slots 0..k-1 retire (if retirable). The faulting entry reaches slot 0 on a later cycle.
// - amt = count of head_iqrel bits among retired slots; amt <= ramt always.
// - FLUSH: ramt=amt=0 regardless of inputs; head status is ignored.
// - All head_v=0: ramt=0 and stall_cnt does not increment.
// - ramt/amt are combinational from inputs and state (zero-cycle latency). All other outputs are registered.
// - commit_cnt += ramt, 32-bit wrap modulo 2^32. stall_cnt increments in RUN when head_v[0]=1 and ramt=0, 32-bit wrap.
// STRUCTURE
// - Shared package: commit_state_t enum {RUN, FLUSH}; CAUSE_W; COMMIT_WIDTH default.
//   These constants are also consumed by the ROB and exception unit.
// - One sub-module, commit_prefix: combinational leading-run scanner.
//   Inputs: per-slot retirable terms and store/iqrel masks. Outputs: ramt, amt, slot-0 exception flag.
// - Top level holds the FSM, flush counter and statistics counters.
// TESTING
// 1. All 3 slots v,done, no store, iqrel=101 -> ramt=3, amt=2; commit_cnt +3 next cycle.
// 2. Slots 0,1 stores, sb_full=0 -> ramt=1. Same with sb_full=1 -> ramt=0; stall_cnt +1.
// 3. Slot 1 exc, slots 0,1 done -> ramt=1.
//    Next cycle the faulting entry is at slot 0 with exc, cause 8'h21 -> ramt=1.
//    Then exc_valid pulse, exc_cause=8'h21, flush=1 for 4 cycles with ramt=0, then RUN resumes.
// 4. Slot 0 v & !done -> ramt=0 even though slots 1,2 are done; stall_cnt increments every cycle held.
// 5. rst asserted in FLUSH cycle 2 -> next cycle flush=0, state RUN, counters 0, ramt=0 while rst=1.
// 6. Preload commit_cnt near 32'hFFFFFFFE, retire 3 -> commit_cnt wraps to 32'h00000001.

Source files
------------

// File: rtl/commit_pkg.sv
// -----------------------------------------------------------------------------
// commit_pkg
// Shared constants and types for the commit path. The ROB and exception unit
// consume the same CAUSE_W / COMMIT_WIDTH values, so they live here.
// -----------------------------------------------------------------------------
package commit_pkg;

  // Default number of ROB head slots inspected per cycle (max 7: ramt is 3 bits)
  localparam int COMMIT_WIDTH = 3;
  // Default number of cycles flush is held after an exception commits
  localparam int FLUSH_CYCLES = 4;
  // Exception cause width
  localparam int CAUSE_W      = 8;
  // Width of the retire / release amounts
  localparam int AMT_W        = 3;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_t;

endpackage : commit_pkg

// File: rtl/commit_ctrl_prefix.sv
// -----------------------------------------------------------------------------
// commit_prefix
// Combinational leading-run scanner. Walks the head slots oldest-first and
// counts how many retire this cycle, stopping at the first slot that cannot.
// At most one store retires per cycle, and only when the store buffer has room.
// A completed exception in slot 0 overrides the scan and retires that slot alone.
//
// Ports
//   en_i       : scanning allowed (RUN state and not in reset)
//   ok_i       : per-slot valid & done & !exc
//   exc0_i     : slot 0 valid & done & exc
//   store_i    : per-slot store flag
//   iqrel_i    : per-slot "still owns an IQ entry" flag
//   sb_full_i  : store buffer cannot accept
//   ramt_o     : ROB entries retired
//   amt_o      : IQ entries released (always <= ramt_o)
//   exc0_o     : slot 0 exception is committing this cycle
// -----------------------------------------------------------------------------
module commit_prefix
  import commit_pkg::*;
#(
  parameter int COMMIT_WIDTH = commit_pkg::COMMIT_WIDTH
) (
  input  logic                    en_i,
  input  logic [COMMIT_WIDTH-1:0] ok_i,
  input  logic                    exc0_i,
  input  logic [COMMIT_WIDTH-1:0] store_i,
  input  logic [COMMIT_WIDTH-1:0] iqrel_i,
  input  logic                    sb_full_i,
  output logic [AMT_W-1:0]        ramt_o,
  output logic [AMT_W-1:0]        amt_o,
  output logic                    exc0_o
);

  // Leading-run scan over the head slots
  always_comb begin
    logic scan;
    logic st_used;
    logic take;
    ramt_o  = 3'd0;
    amt_o   = 3'd0;
    exc0_o  = 1'b0;
    scan    = 1'b1;
    st_used = 1'b0;
    take    = 1'b0;
    if (en_i) begin
      if (exc0_i) begin
        // Faulting entry at the head retires alone; it triggers the flush.
        ramt_o = 3'd1;
        amt_o  = {2'b00, iqrel_i[0]};
        exc0_o = 1'b1;
      end else begin
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          take = scan && ok_i[k] && (!store_i[k] || (!sb_full_i && !st_used));
          if (take) begin
            ramt_o = ramt_o + 3'd1;
            amt_o  = amt_o + {2'b00, iqrel_i[k]};
            if (store_i[k]) begin
              st_used = 1'b1;
            end else begin
              st_used = st_used;
            end
          end else begin
            // First slot that cannot retire ends the run for younger slots.
            scan = 1'b0;
          end
        end
      end
    end else begin
      exc0_o = 1'b0;
    end
  end

endmodule : commit_prefix

// File: rtl/commit_ctrl.sv
// -----------------------------------------------------------------------------
// commit_ctrl
// Commit-width controller upstream of the head-pointer block. Decides each
// cycle how many of the oldest ROB entries retire (ramt) and how many IQ
// entries they release (amt); both are combinational so the head pointers
// advance on the same edge. Sequences the exception flush and keeps
// commit/stall statistics.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   head_v/done/exc/store/iqrel : per-slot head status, slot 0 = oldest
//   head_cause   : per-slot cause, slot k at [k*CAUSE_W +: CAUSE_W]
//   sb_full      : store buffer cannot accept
//   ramt, amt    : retired ROB entries / released IQ entries (combinational)
//   flush        : flush request, held FLUSH_CYCLES cycles after an exception
//   exc_valid    : one-cycle pulse after an exception commits
//   exc_cause    : cause of the last committed exception
//   commit_cnt   : total retired entries (wraps)
//   stall_cnt    : RUN cycles with a valid head that retired nothing (wraps)
// -----------------------------------------------------------------------------
module commit_ctrl #(
  parameter int COMMIT_WIDTH = commit_pkg::COMMIT_WIDTH,
  parameter int FLUSH_CYCLES = commit_pkg::FLUSH_CYCLES,
  parameter int CAUSE_W      = commit_pkg::CAUSE_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COMMIT_WIDTH-1:0]         head_v,
  input  logic [COMMIT_WIDTH-1:0]         head_done,
  input  logic [COMMIT_WIDTH-1:0]         head_exc,
  input  logic [COMMIT_WIDTH-1:0]         head_store,
  input  logic [COMMIT_WIDTH-1:0]         head_iqrel,
  input  logic [COMMIT_WIDTH*CAUSE_W-1:0] head_cause,
  input  logic                            sb_full,
  output logic [2:0]                      ramt,
  output logic [2:0]                      amt,
  output logic                            flush,
  output logic                            exc_valid,
  output logic [CAUSE_W-1:0]              exc_cause,
  output logic [31:0]                     commit_cnt,
  output logic [31:0]                     stall_cnt
);

  import commit_pkg::*;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  commit_state_t            state_q;
  logic                     flush_q;
  logic                     exc_valid_q;
  logic [CAUSE_W-1:0]       exc_cause_q;
  logic [31:0]              commit_cnt_q;
  logic [31:0]              commit_cnt_d;
  logic [31:0]              stall_cnt_q;
  logic [31:0]              stall_cnt_d;
  logic [FC_W-1:0]          fcnt_q;

  logic                     en_s;
  logic [COMMIT_WIDTH-1:0]  ok_s;
  logic                     exc0_term_s;
  logic [2:0]               ramt_s;
  logic [2:0]               amt_s;
  logic                     exc0_s;
  logic                     cause_unused_s;

  // Only slot 0's cause is ever latched; younger slots reach slot 0 later.
  assign cause_unused_s = ^head_cause[COMMIT_WIDTH*CAUSE_W-1:CAUSE_W];

  assign en_s        = !rst && (state_q == RUN);
  assign ok_s        = head_v & head_done & ~head_exc;
  assign exc0_term_s = head_v[0] & head_done[0] & head_exc[0];

  commit_prefix #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_prefix (
    .en_i      (en_s),
    .ok_i      (ok_s),
    .exc0_i    (exc0_term_s),
    .store_i   (head_store),
    .iqrel_i   (head_iqrel),
    .sb_full_i (sb_full),
    .ramt_o    (ramt_s),
    .amt_o     (amt_s),
    .exc0_o    (exc0_s)
  );

  // Next values of the statistics counters
  always_comb begin
    commit_cnt_d = commit_cnt_q + 32'(ramt_s);
    stall_cnt_d  = stall_cnt_q;
    if ((state_q == RUN) && head_v[0] && (ramt_s == 3'd0)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // FSM, flush counter, exception capture and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_q      <= 1'b0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= '0;
      commit_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
      fcnt_q       <= '0;
    end else begin
      exc_valid_q  <= 1'b0;
      commit_cnt_q <= commit_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      case (state_q)
        RUN: begin
          if (exc0_s) begin
            state_q     <= FLUSH;
            flush_q     <= 1'b1;
            exc_valid_q <= 1'b1;
            exc_cause_q <= head_cause[CAUSE_W-1:0];
            // Counts down to zero; flush drops on the edge where it is zero.
            fcnt_q      <= FC_W'(FLUSH_CYCLES - 1);
          end else begin
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end else begin
            fcnt_q  <= fcnt_q - FC_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign ramt       = ramt_s;
  assign amt        = amt_s;
  assign flush      = flush_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;
  assign commit_cnt = commit_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule : commit_ctrl
